serial_bus_master: RTL
======================

# serial_bus_master

Parametrised master for the one-wire-each-way serial register link between the Microzed PL and a remote FPGA's bus FSM. Accepts single-cycle read/write requests from the local register bus and serialises address, data and opcode as framed 13-bit symbols. It then deframes the remote response bytes and returns read data and status with a done pulse. Unlike the fixed 16-bit shift-out path, it supports:

- configurable address and data widths;
- transaction state with busy/done handshake;
- a response timeout;
- sent/seen byte counters.

## Interface
- ADDR_W, 16, address width in bits; multiple of 8, 8..32
- DATA_W, 16, data width in bits; multiple of 8, 8..32
- TIMEOUT, 1023, cycles allowed in WAIT before aborting; ≥ 16
- WR_OP, 8'h01, opcode byte for write
- RD_OP, 8'h02, opcode byte for read
- clk  in  1  single clock (fclk0 domain)
- rst  in  1  reset; synchronous, active-high
- req_wr  in  1  one-cycle write request
- req_rd  in  1  one-cycle read request
- req_addr  in  ADDR_W  address, sampled with request
- req_wdata  in  DATA_W  write data, sampled with req_wr
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- timeout  out  1  status of the last transaction: it ended by timeout
- rsp_rdata  out  DATA_W  read data from the last response
- rsp_status  out  8  status byte from the last response
- ser_out  out  1  serial line to the remote FPGA (registered)
- ser_in  in  1  serial line from the remote FPGA (asynchronous)
- bytes_sent  out  16  symbols transmitted; wraps
- bytes_seen  out  16  symbols received; wraps

## Operation
- **Symbol format**, 13 bits, MSB first: 0, 1, flag, d7..d0, 0, 0. A flag of 1 marks the last symbol of a frame.
- **Write frame:**
  - DATA_W/8 data bytes, MSB byte first, then ADDR_W/8 address bytes, MSB first; all with flag 0.
  - Then WR_OP with flag 1.
- **Read frame:** ADDR_W/8 address bytes with flag 0, then RD_OP with flag 1.
- **FSM states:**
  - IDLE: on req_wr or req_rd, latch the frame into a shift register, clear the response accumulator and timeout, go to SEND. req_wr wins if both are asserted.
  - SEND: shift one bit per cycle. After the final bit of the opcode symbol, go to WAIT.
  - WAIT: on a received symbol with flag 1, update rsp_*, pulse done, clear timeout, go to IDLE. If TIMEOUT cycles elapse first, pulse done, set timeout=1, go to IDLE.
- Requests arriving while busy are ignored with no side effects. busy = (state≠IDLE).
- **Receiver** (always running):
  - ser_in passes through a 2-flop synchroniser into a 12-bit shift register.
  - A symbol is detected when sr[11]=1 and sr[1:0]=00; byte = sr[9:2], flag = sr[10]. The register is then cleared.
  - Each detected byte shifts into a DATA_W+8 bit accumulator (LSB end) and increments bytes_seen.
  - On flag=1 in WAIT: rsp_status = acc[7:0] and rsp_rdata = acc[DATA_W+7:8], both including the flagged byte.
  - A flagged symbol outside WAIT is counted and discarded; rsp_* do not change.
- bytes_sent increments once per transmitted symbol, at its first bit.
- **Reset values:** state=IDLE, busy=0, done=0, timeout=0, rsp_rdata=0, rsp_status=0, ser_out=0, both counters 0, shift registers 0.
- **Reset mid-transaction:** aborts at once, with no done pulse. ser_out goes to 0 on the next edge.

## Timing
- Request sampled at edge 0; busy=1 after edge 0; first frame bit (0) on ser_out after edge 1.
- Frame duration: 13×(number of symbols) cycles. Write with 16/16 widths: 5 symbols, 65 cycles. Read: 3 symbols, 39 cycles.
- busy falls in the same cycle that done is high. A new request is accepted on the cycle after done.
- Receive latency: 2 synchroniser cycles plus 12 shift cycles from the start bit to detection. done and rsp_* are valid the cycle after detection.
- Timeout: done is asserted exactly TIMEOUT cycles after WAIT entry if no flagged symbol arrives. A flagged symbol detected in that same cycle takes priority (timeout=0).

## Structure
- Package serial_link_pkg holds:
  - SYM_W=13;
  - preamble 2'b01 and trailer 2'b00;
  - state encodings IDLE/SEND/WAIT;
  - default opcode values.
- Sub-module serial_byte_rx: synchroniser, 12-bit deframer, and outputs byte_valid/byte/flag.
- Top level: FSM, frame builder, timeout counter, accumulator, counters.

## Test plan
- **Write, defaults:** req_wr with addr=0x0003, wdata=0xBEEF → ser_out carries symbols BE, EF, 00, 03, then 01 with flag, over 65 cycles. bytes_sent=5.
- **Read loopback:** bench remote model replies to req_rd addr 0x0001 with symbols BE, EF, then 00 with flag → done, rsp_rdata=0xBEEF, rsp_status=0x00, timeout=0, bytes_seen=3.
- **Timeout:** no reply, TIMEOUT=100 → done exactly 100 cycles after WAIT entry, timeout=1, rsp_* unchanged.
- **Busy drop and priority:**
  - req_rd during SEND → ignored; bytes_sent is unchanged after the frame.
  - Simultaneous req_wr and req_rd in IDLE → a write frame is sent.
- **Widths:** ADDR_W=8, DATA_W=32 write of 0x12345678 to 0x7F → 6 symbols: 12, 34, 56, 78, 7F, then 01 with flag.
- **Reset and stray input:**
  - rst asserted mid-SEND → next cycle busy=0, ser_out=0, no done.
  - A stray flagged symbol in IDLE → bytes_seen increments and rsp_status is unchanged.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial register link: symbol framing,
// master FSM state encoding and default opcode bytes.
package serial_link_pkg;

  // One symbol on the wire: 0, 1, flag, d7..d0, 0, 0 (MSB first).
  localparam int SYM_W = 13;

  localparam logic [1:0] SYM_PREAMBLE = 2'b01;
  localparam logic [1:0] SYM_TRAILER  = 2'b00;

  localparam logic [7:0] DEF_WR_OP = 8'h01;
  localparam logic [7:0] DEF_RD_OP = 8'h02;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Build one framed symbol; last=1 marks the final symbol of a frame.
  function automatic logic [SYM_W-1:0] sym_encode(input logic [7:0] data,
                                                  input logic       last);
    return {SYM_PREAMBLE, last, data, SYM_TRAILER};
  endfunction

endpackage

// File: rtl/serial_byte_rx.sv
// Always-running receiver: 2-flop synchroniser on the asynchronous line,
// then a 12-bit deframer. The leading 0 of each symbol is not stored, so a
// symbol is complete when the preamble 1 reaches bit 11 with the trailer
// zeros in bits 1:0. byte_valid is a one-cycle decode of the register.
module serial_byte_rx
  import serial_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       flag
);

  logic        sync1;
  logic        sync2;
  logic [11:0] sr;

  assign byte_valid = sr[11] && (sr[1:0] == SYM_TRAILER);
  assign byte_data  = sr[9:2];
  assign flag       = sr[10];

  // Synchronise the line and shift it in; clear after each detected symbol
  // so stale bits can never alias into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sr    <= '0;
    end else begin
      sync1 <= ser_in;
      sync2 <= sync1;
      if (byte_valid) sr <= '0;
      else            sr <= {sr[10:0], sync2};
    end
  end

endmodule

// File: rtl/serial_bus_master.sv
// Serial register-link master: frames local read/write requests into
// 13-bit symbols on ser_out, then collects the remote response bytes from
// ser_in and reports read data, status and timeout with a done pulse.
//
// Handshake: req_wr/req_rd are one-cycle valids with no ready; they are
// taken only while busy=0 (IDLE) and dropped without effect otherwise.
// busy rises the cycle after acceptance and falls in the cycle done is
// high; done is a one-cycle pulse and rsp_*/timeout are valid with it.
module serial_bus_master
  import serial_link_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter int         DATA_W  = 16,
  parameter int         TIMEOUT = 1023,
  parameter logic [7:0] WR_OP   = DEF_WR_OP,
  parameter logic [7:0] RD_OP   = DEF_RD_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_wr,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        rsp_status,
  output logic              ser_out,
  input  logic              ser_in,
  output logic [15:0]       bytes_sent,
  output logic [15:0]       bytes_seen,
  output state_e            state_dbg
);

  localparam int AB      = ADDR_W / 8;
  localparam int DB      = DATA_W / 8;
  localparam int WR_SYMS = DB + AB + 1;
  localparam int RD_SYMS = AB + 1;
  localparam int FRAME_W = SYM_W * WR_SYMS;
  localparam int ACC_W   = DATA_W + 8;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       SYM_LAST_BIT = 4'(SYM_W - 1);

  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] frame_sr;
  logic [FRAME_W-1:0] wr_frame;
  logic [FRAME_W-1:0] rd_frame;
  logic [3:0]         bit_idx;
  logic [3:0]         sym_left;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic               rx_valid;
  logic               rx_flag;
  logic [7:0]         rx_byte;
  logic               accept;
  logic               send_last;
  logic               rsp_hit;
  logic               tmo_hit;

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
  assign acc_next  = {acc[ACC_W-9:0], rx_byte};

  serial_byte_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .flag       (rx_flag)
  );

  // Frame builder: both candidate frames left-aligned, MSB byte first.
  always_comb begin
    wr_frame = '0;
    rd_frame = '0;
    for (int i = 0; i < DB; i++) begin
      wr_frame[FRAME_W-1-SYM_W*i -: SYM_W] =
        sym_encode(req_wdata[DATA_W-1-8*i -: 8], 1'b0);
    end
    for (int i = 0; i < AB; i++) begin
      wr_frame[FRAME_W-1-SYM_W*(DB+i) -: SYM_W] =
        sym_encode(req_addr[ADDR_W-1-8*i -: 8], 1'b0);
      rd_frame[FRAME_W-1-SYM_W*i -: SYM_W] =
        sym_encode(req_addr[ADDR_W-1-8*i -: 8], 1'b0);
    end
    wr_frame[FRAME_W-1-SYM_W*(DB+AB) -: SYM_W] = sym_encode(WR_OP, 1'b1);
    rd_frame[FRAME_W-1-SYM_W*AB -: SYM_W]      = sym_encode(RD_OP, 1'b1);
  end

  // Next-state logic and the per-cycle events that drive the datapath.
  // A flagged symbol wins over the timeout expiring in the same cycle.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    send_last = 1'b0;
    rsp_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        accept = req_wr || req_rd;
        if (accept) state_d = SEND;
      end
      SEND: begin
        send_last = (bit_idx == SYM_LAST_BIT) && (sym_left == 4'd1);
        if (send_last) state_d = WAIT;
      end
      WAIT: begin
        rsp_hit = rx_valid && rx_flag;
        tmo_hit = (tmo_cnt == TMO_LAST) && !rsp_hit;
        if (rsp_hit || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Transmit path: load the frame on acceptance, then one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sr   <= '0;
      bit_idx    <= '0;
      sym_left   <= '0;
      ser_out    <= 1'b0;
      bytes_sent <= '0;
    end else if (accept) begin
      frame_sr <= req_wr ? wr_frame : rd_frame;
      sym_left <= req_wr ? 4'(WR_SYMS) : 4'(RD_SYMS);
      bit_idx  <= '0;
      ser_out  <= 1'b0;
    end else if (state_q == SEND) begin
      ser_out  <= frame_sr[FRAME_W-1];
      frame_sr <= frame_sr << 1;
      if (bit_idx == 4'd0) bytes_sent <= bytes_sent + 16'd1;
      if (bit_idx == SYM_LAST_BIT) begin
        bit_idx  <= '0;
        sym_left <= sym_left - 4'd1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      ser_out <= 1'b0;
    end
  end

  // Response side: timeout count, accumulator, status outputs, rx counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      timeout    <= 1'b0;
      done       <= 1'b0;
      acc        <= '0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
      bytes_seen <= '0;
    end else begin
      done <= rsp_hit || tmo_hit;
      if (accept) begin
        tmo_cnt <= '0;
        timeout <= 1'b0;
      end else if (state_q == WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (rsp_hit) begin
        rsp_status <= acc_next[7:0];
        rsp_rdata  <= acc_next[ACC_W-1:8];
        timeout    <= 1'b0;
      end else if (tmo_hit) begin
        timeout <= 1'b1;
      end
      if (accept)        acc <= '0;
      else if (rx_valid) acc <= acc_next;
      if (rx_valid) bytes_seen <= bytes_seen + 16'd1;
    end
  end

endmodule
